// File: rtl/sr_pulse_gen.sv
// Debounces raw set/clear requests and turns debounced rising edges into mutually exclusive
// one-cycle s/r pulses for a downstream SR flop. Define SR_PULSE_GEN_SYNC_EN for 2-flop input synchronizers.
module sr_pulse_gen #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic set_lvl,
   output logic clr_lvl,
   output logic conflict
);

   localparam int            CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

   logic [1:0] raw;
   logic [1:0] lvl;
   logic [1:0] rise;
   logic       s_reg;
   logic       r_reg;
   logic       conflict_reg;

   // Channel 0 is set, channel 1 is clear.
   assign raw = {clr_req, set_req};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic          samp_in;
         logic          samp_reg;
         logic [CW-1:0] cnt_reg;
         logic          stable_reg;
         logic          stable_d_reg;

`ifdef SR_PULSE_GEN_SYNC_EN
         logic [1:0] sync_reg;

         always_ff @(posedge clk) begin
            if (rst) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= {sync_reg[0], raw[gi]};
            end
         end

         assign samp_in = sync_reg[1];
`else
         assign samp_in = raw[gi];
`endif

         // Any sample matching the accepted level restarts the count, so only an
         // unbroken run of DB_CYCLES differing samples changes the level.
         always_ff @(posedge clk) begin
            if (rst) begin
               samp_reg     <= 1'b0;
               cnt_reg      <= '0;
               stable_reg   <= 1'b0;
               stable_d_reg <= 1'b0;
            end else begin
               samp_reg     <= samp_in;
               stable_d_reg <= stable_reg;
               if (samp_reg != stable_reg) begin
                  if (cnt_reg == CNT_MAX) begin
                     stable_reg <= samp_reg;
                     cnt_reg    <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign lvl[gi]  = stable_reg;
         assign rise[gi] = stable_reg & ~stable_d_reg;
      end
   endgenerate

   // Same-cycle rises cancel each other so the flop never sees s and r together.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_reg        <= 1'b0;
         r_reg        <= 1'b0;
         conflict_reg <= 1'b0;
      end else begin
         s_reg        <= rise[0] & ~rise[1];
         r_reg        <= rise[1] & ~rise[0];
         conflict_reg <= rise[0] & rise[1];
      end
   end

   assign s        = s_reg;
   assign r        = r_reg;
   assign conflict = conflict_reg;
   assign set_lvl  = lvl[0];
   assign clr_lvl  = lvl[1];

endmodule
